// File: rtl/axi_stream_sideband_crc.sv
`default_nettype none
// ============================================================================
// Module      : axi_stream_sideband_crc
// Description : AXI4-Stream pass-through stage that appends a CRC trailer
//               beat to every packet. Data beats go through one output
//               register. The CRC is computed elsewhere and arrives on a
//               sideband input. After a packet's last beat the block waits
//               for that CRC and emits it as an extra, flagged final beat.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   sole clock, rising edge
//   srst         in   asynchronous reset, active low
//   i_s_tdata    in   slave payload
//   i_s_tkeep    in   slave byte enables (forwarded, never interpreted)
//   i_s_tlast    in   slave end-of-packet (consumed, not forwarded)
//   i_s_tvalid   in   slave valid
//   o_s_tready   out  slave ready (combinational)
//   crc          in   {crc_valid, crc_value}
//   o_m_tdata    out  {crc_beat_flag, payload}
//   o_m_tkeep    out  master byte enables
//   o_m_tlast    out  master end-of-packet, set only on the CRC beat
//   o_m_tvalid   out  master valid
//   i_m_tready   in   master ready
// ============================================================================
module axi_stream_sideband_crc #(
    parameter int DATA_WIDTH = 512,
    parameter int CRC_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic [DATA_WIDTH-1:0]   i_s_tdata,
    input  logic [DATA_WIDTH/8-1:0] i_s_tkeep,
    input  logic                    i_s_tlast,
    input  logic                    i_s_tvalid,
    output logic                    o_s_tready,
    input  logic [CRC_WIDTH:0]      crc,
    output logic [DATA_WIDTH:0]     o_m_tdata,
    output logic [DATA_WIDTH/8-1:0] o_m_tkeep,
    output logic                    o_m_tlast,
    output logic                    o_m_tvalid,
    input  logic                    i_m_tready
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    // Byte-enable pattern of the CRC beat: the low CRC_WIDTH/8 bytes.
    function automatic logic [KEEP_WIDTH-1:0] crc_keep_mask();
        logic [KEEP_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < CRC_WIDTH / 8; i++) begin
            m[i] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [KEEP_WIDTH-1:0] c_CRC_KEEP = crc_keep_mask();

    typedef enum logic [0:0] {
        ST_PASS     = 1'b0,
        ST_WAIT_CRC = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [DATA_WIDTH:0]     r_m_tdata;
    logic [KEEP_WIDTH-1:0]   r_m_tkeep;
    logic                    r_m_tlast;
    logic                    r_m_tvalid;

    logic                    w_free;
    logic                    w_s_tready;
    logic                    w_load_data;
    logic                    w_load_crc;
    logic [DATA_WIDTH-1:0]   w_crc_payload;

    // The output register can take a new beat when empty or being drained.
    assign w_free = !r_m_tvalid || i_m_tready;

    // CRC value zero-extended to the payload width; written bit-wise so the
    // equal-width configuration needs no zero-length replication.
    always_comb begin
        w_crc_payload                  = '0;
        w_crc_payload[CRC_WIDTH-1:0]   = crc[CRC_WIDTH-1:0];
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge srst) begin
        if (!srst) begin
            r_state <= ST_PASS;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_s_tready   = 1'b0;
        w_load_data  = 1'b0;
        w_load_crc   = 1'b0;
        case (r_state)
            ST_PASS: begin
                // Gated by srst so the slave never sees ready while the
                // block is held in reset.
                w_s_tready  = w_free && srst;
                w_load_data = i_s_tvalid && w_s_tready;
                if (w_load_data && i_s_tlast) begin
                    w_state_next = ST_WAIT_CRC;
                end
            end
            ST_WAIT_CRC: begin
                // The CRC value is sampled only on the cycle it is loaded.
                w_load_crc = crc[CRC_WIDTH] && w_free;
                if (w_load_crc) begin
                    w_state_next = ST_PASS;
                end
            end
            default: begin
                w_state_next = ST_PASS;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge srst) begin
        if (!srst) begin
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tlast  <= 1'b0;
            r_m_tvalid <= 1'b0;
        end else if (w_load_data) begin
            r_m_tdata  <= {1'b0, i_s_tdata};
            r_m_tkeep  <= i_s_tkeep;
            r_m_tlast  <= 1'b0;
            r_m_tvalid <= 1'b1;
        end else if (w_load_crc) begin
            r_m_tdata  <= {1'b1, w_crc_payload};
            r_m_tkeep  <= c_CRC_KEEP;
            r_m_tlast  <= 1'b1;
            r_m_tvalid <= 1'b1;
        end else if (i_m_tready) begin
            // Drained with nothing new to load; payload fields are left
            // as they were since they are qualified by valid.
            r_m_tvalid <= 1'b0;
        end
    end

    assign o_s_tready = w_s_tready;
    assign o_m_tdata  = r_m_tdata;
    assign o_m_tkeep  = r_m_tkeep;
    assign o_m_tlast  = r_m_tlast;
    assign o_m_tvalid = r_m_tvalid;

endmodule
`default_nettype wire

// File: tb/tb_axi_stream_sideband_crc.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_stream_sideband_crc
// Description : Directed self-checking bench for axi_stream_sideband_crc with
//               default widths (512-bit data, 32-bit CRC). Inputs change on
//               the falling edge; outputs are sampled 4 ns later, just before
//               the next rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_stream_sideband_crc;

    localparam int DW = 512;
    localparam int CW = 32;
    localparam int KW = DW / 8;

    typedef struct packed {
        logic [DW:0]   d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    logic          clk        = 1'b0;
    logic          srst       = 1'b1;
    logic [DW-1:0] i_s_tdata  = '0;
    logic [KW-1:0] i_s_tkeep  = '0;
    logic          i_s_tlast  = 1'b0;
    logic          i_s_tvalid = 1'b0;
    logic          o_s_tready;
    logic [CW:0]   crc        = '0;
    logic [DW:0]   o_m_tdata;
    logic [KW-1:0] o_m_tkeep;
    logic          o_m_tlast;
    logic          o_m_tvalid;
    logic          i_m_tready = 1'b1;

    logic          ready_level = 1'b1;
    logic          toggle_en   = 1'b0;

    int            n_cmp = 0;
    int            n_bad = 0;
    beat_t         q[$];

    axi_stream_sideband_crc #(
        .DATA_WIDTH (DW),
        .CRC_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .srst       (srst),
        .i_s_tdata  (i_s_tdata),
        .i_s_tkeep  (i_s_tkeep),
        .i_s_tlast  (i_s_tlast),
        .i_s_tvalid (i_s_tvalid),
        .o_s_tready (o_s_tready),
        .crc        (crc),
        .o_m_tdata  (o_m_tdata),
        .o_m_tkeep  (o_m_tkeep),
        .o_m_tlast  (o_m_tlast),
        .o_m_tvalid (o_m_tvalid),
        .i_m_tready (i_m_tready)
    );

    always #5 clk = ~clk;

    // Master ready: steady level or toggled every cycle.
    always @(negedge clk) begin
        i_m_tready = toggle_en ? ~i_m_tready : ready_level;
    end

    // Collect every beat the master port hands over.
    always @(negedge clk) begin
        #4;
        if (srst && o_m_tvalid && i_m_tready) begin
            q.push_back('{d: o_m_tdata, k: o_m_tkeep, l: o_m_tlast});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // --------------------------------------------------------------------
    // Expected-beat builders
    // --------------------------------------------------------------------
    function automatic beat_t data_beat(input logic [DW-1:0] d, input logic [KW-1:0] k);
        beat_t b;
        b.d = {1'b0, d};
        b.k = k;
        b.l = 1'b0;
        return b;
    endfunction

    function automatic beat_t crc_beat(input logic [CW-1:0] v);
        beat_t b;
        b.d        = '0;
        b.d[DW]    = 1'b1;
        b.d[CW-1:0] = v;
        b.k        = '0;
        b.k[3:0]   = 4'hF;
        b.l        = 1'b1;
        return b;
    endfunction

    function automatic beat_t q_at(input int i);
        beat_t b;
        b = '0;
        if (q.size() > i) b = q[i];
        return b;
    endfunction

    // --------------------------------------------------------------------
    // Stimulus helpers (no checking inside)
    // --------------------------------------------------------------------
    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                             input logic l, output int waits, output bit ok);
        waits = 0;
        ok    = 1'b0;
        @(negedge clk);
        i_s_tdata  = d;
        i_s_tkeep  = k;
        i_s_tlast  = l;
        i_s_tvalid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            #4;
            if (o_s_tready) begin
                @(posedge clk);
                #1;
                i_s_tvalid = 1'b0;
                i_s_tlast  = 1'b0;
                ok = 1'b1;
                break;
            end
            waits++;
            @(negedge clk);
        end
        i_s_tvalid = 1'b0;
    endtask

    task automatic wait_q(input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #4;
        end
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) @(negedge clk);
    endtask

    // --------------------------------------------------------------------
    // Tests
    // --------------------------------------------------------------------
    task automatic test_reset();
        #1 srst = 1'b0;
        idle(2);
        #4;
        n_cmp++; if (o_m_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid: got %b expected 0", o_m_tvalid); end
        n_cmp++; if (o_m_tlast !== 1'b0) begin n_bad++; $display("FAIL reset_tlast: got %b expected 0", o_m_tlast); end
        n_cmp++; if (o_m_tdata !== '0) begin n_bad++; $display("FAIL reset_tdata: got %h expected 0", o_m_tdata); end
        n_cmp++; if (o_m_tkeep !== '0) begin n_bad++; $display("FAIL reset_tkeep: got %h expected 0", o_m_tkeep); end
        n_cmp++; if (o_s_tready !== 1'b0) begin n_bad++; $display("FAIL reset_s_tready: got %b expected 0", o_s_tready); end
        @(negedge clk);
        srst = 1'b1;
        #4;
        n_cmp++; if (o_s_tready !== 1'b1) begin n_bad++; $display("FAIL release_s_tready: got %b expected 1", o_s_tready); end
    endtask

    task automatic test_basic();
        int    w;
        bit    ok, all_ok;
        beat_t e, g;
        all_ok = 1'b1;
        q.delete();
        crc = {1'b1, 32'hDEADBEEF};
        for (int i = 0; i < 3; i++) begin
            send_beat({DW{1'b1}}, '0, (i == 2), w, ok);
            all_ok &= ok;
        end
        wait_q(4, ok);
        all_ok &= ok;
        n_cmp++; if (!all_ok) begin n_bad++; $display("FAIL basic_handshake: got timeout expected completion"); end
        for (int i = 0; i < 4; i++) begin
            e = (i < 3) ? data_beat({DW{1'b1}}, '0) : crc_beat(32'hDEADBEEF);
            g = q_at(i);
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL basic_beat%0d: got d=%h k=%h l=%b expected d=%h k=%h l=%b", i, g.d, g.k, g.l, e.d, e.k, e.l);
            end
        end
        crc = '0;
        idle(2);
    endtask

    task automatic test_crc_delay();
        int    w;
        bit    ok;
        beat_t e, g;
        logic [DW-1:0] d;
        q.delete();
        crc = '0;
        d = '0;
        d[15:0] = 16'h1234;
        send_beat(d, {KW{1'b1}}, 1'b1, w, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL delay_accept: got timeout expected accept"); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #4;
            n_cmp++; if (o_s_tready !== 1'b0) begin n_bad++; $display("FAIL delay_bubble%0d: got s_tready=%b expected 0", c, o_s_tready); end
        end
        @(negedge clk);
        crc = {1'b1, 32'hCAFEF00D};
        #4;
        n_cmp++; if (o_m_tvalid !== 1'b0) begin n_bad++; $display("FAIL delay_early: got tvalid=%b expected 0", o_m_tvalid); end
        @(negedge clk);
        #4;
        e = crc_beat(32'hCAFEF00D);
        n_cmp++;
        if (o_m_tvalid !== 1'b1 || o_m_tdata !== e.d || o_m_tlast !== 1'b1) begin
            n_bad++;
            $display("FAIL delay_crc_beat: got v=%b d=%h l=%b expected v=1 d=%h l=1", o_m_tvalid, o_m_tdata, o_m_tlast, e.d);
        end
        crc = '0;
        wait_q(2, ok);
        e = data_beat(d, {KW{1'b1}});
        g = q_at(0);
        n_cmp++; if (g !== e) begin n_bad++; $display("FAIL delay_data_beat: got d=%h l=%b expected d=%h l=0", g.d, g.l, e.d); end
        idle(2);
    endtask

    task automatic test_backpressure();
        bit    all_ok, ok;
        beat_t e, g;
        logic [DW+KW+1:0] prev, cur;
        bit    prev_stall;
        all_ok     = 1'b1;
        prev       = '0;
        prev_stall = 1'b0;
        q.delete();
        crc = {1'b1, 32'h0BADF00D};
        toggle_en = 1'b1;
        fork
            begin
                int w;
                for (int i = 0; i < 4; i++) begin
                    send_beat(DW'(i + 1), {KW{1'b1}}, (i == 3), w, ok);
                    all_ok &= ok;
                end
            end
            begin
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    #4;
                    cur = {o_m_tdata, o_m_tkeep, o_m_tlast, o_m_tvalid};
                    if (prev_stall) begin
                        n_cmp++;
                        if (cur !== prev) begin
                            n_bad++;
                            $display("FAIL stall_stable: got d=%h l=%b v=%b expected unchanged", o_m_tdata, o_m_tlast, o_m_tvalid);
                        end
                    end
                    prev       = cur;
                    prev_stall = o_m_tvalid && !i_m_tready;
                end
            end
        join
        wait_q(5, ok);
        all_ok &= ok;
        toggle_en = 1'b0;
        crc = '0;
        n_cmp++; if (!all_ok) begin n_bad++; $display("FAIL bp_handshake: got timeout expected completion"); end
        for (int i = 0; i < 5; i++) begin
            e = (i < 4) ? data_beat(DW'(i + 1), {KW{1'b1}}) : crc_beat(32'h0BADF00D);
            g = q_at(i);
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL bp_beat%0d: got d=%h l=%b expected d=%h l=%b", i, g.d, g.l, e.d, e.l);
            end
        end
        idle(4);
        n_cmp++; if (q.size() != 5) begin n_bad++; $display("FAIL bp_count: got %0d expected 5", q.size()); end
    endtask

    task automatic test_crc_ignored();
        int    w;
        bit    ok, all_ok;
        beat_t e, g;
        all_ok = 1'b1;
        q.delete();
        crc = {1'b1, 32'h11111111};
        send_beat(DW'(32'hA0), '0, 1'b0, w, ok); all_ok &= ok;
        send_beat(DW'(32'hA1), '0, 1'b0, w, ok); all_ok &= ok;
        crc = '0;
        send_beat(DW'(32'hA2), '0, 1'b1, w, ok); all_ok &= ok;
        n_cmp++; if (!all_ok) begin n_bad++; $display("FAIL ign_handshake: got timeout expected completion"); end
        idle(3);
        #4;
        n_cmp++; if (q.size() != 3 || o_m_tvalid !== 1'b0) begin n_bad++; $display("FAIL ign_no_early_crc: got %0d beats v=%b expected 3 beats v=0", q.size(), o_m_tvalid); end
        @(negedge clk);
        crc = {1'b1, 32'h22222222};
        wait_q(4, ok);
        crc = '0;
        e = crc_beat(32'h22222222);
        g = q_at(3);
        n_cmp++; if (g !== e) begin n_bad++; $display("FAIL ign_crc_value: got d=%h l=%b expected d=%h l=1", g.d, g.l, e.d); end
        idle(2);
    endtask

    task automatic test_back_to_back();
        int    w0, w1, w2;
        bit    ok, all_ok;
        beat_t e, g;
        logic  exp_last [5];
        all_ok = 1'b1;
        q.delete();
        crc = {1'b1, 32'hA5A5A5A5};
        send_beat(DW'(32'h10), {KW{1'b1}}, 1'b0, w0, ok); all_ok &= ok;
        send_beat(DW'(32'h11), {KW{1'b1}}, 1'b1, w1, ok); all_ok &= ok;
        send_beat(DW'(32'h20), {KW{1'b1}}, 1'b1, w2, ok); all_ok &= ok;
        @(negedge clk);
        #4;
        n_cmp++; if (o_s_tready !== 1'b0) begin n_bad++; $display("FAIL b2b_bubble_p2: got s_tready=%b expected 0", o_s_tready); end
        n_cmp++; if (!all_ok) begin n_bad++; $display("FAIL b2b_handshake: got timeout expected completion"); end
        n_cmp++;
        if (w0 != 0 || w1 != 0 || w2 != 1) begin
            n_bad++;
            $display("FAIL b2b_bubbles: got waits %0d/%0d/%0d expected 0/0/1", w0, w1, w2);
        end
        wait_q(5, ok);
        crc = '0;
        exp_last = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: e = data_beat(DW'(32'h10), {KW{1'b1}});
                1: e = data_beat(DW'(32'h11), {KW{1'b1}});
                3: e = data_beat(DW'(32'h20), {KW{1'b1}});
                default: e = crc_beat(32'hA5A5A5A5);
            endcase
            g = q_at(i);
            n_cmp++;
            if (g !== e || g.l !== exp_last[i]) begin
                n_bad++;
                $display("FAIL b2b_beat%0d: got d=%h l=%b expected d=%h l=%b", i, g.d, g.l, e.d, exp_last[i]);
            end
        end
        idle(2);
    endtask

    task automatic test_reset_mid();
        int    w;
        bit    ok;
        beat_t e, g;
        ready_level = 1'b0;
        idle(2);
        send_beat(DW'(32'h77), {KW{1'b1}}, 1'b0, w, ok);
        @(negedge clk);
        #4;
        n_cmp++; if (o_m_tvalid !== 1'b1) begin n_bad++; $display("FAIL rst_mid_held: got tvalid=%b expected 1", o_m_tvalid); end
        #2 srst = 1'b0;
        #1;
        n_cmp++;
        if (o_m_tvalid !== 1'b0 || o_s_tready !== 1'b0 || o_m_tdata !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_async: got v=%b rdy=%b d=%h expected v=0 rdy=0 d=0", o_m_tvalid, o_s_tready, o_m_tdata);
        end
        ready_level = 1'b1;
        crc = {1'b1, 32'h76543210};
        idle(2);
        q.delete();
        srst = 1'b1;
        send_beat(DW'(32'hABC), {KW{1'b1}}, 1'b1, w, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rst_mid_accept: got timeout expected accept"); end
        wait_q(2, ok);
        crc = '0;
        idle(5);
        n_cmp++; if (q.size() != 2) begin n_bad++; $display("FAIL rst_mid_count: got %0d expected 2", q.size()); end
        e = data_beat(DW'(32'hABC), {KW{1'b1}});
        g = q_at(0);
        n_cmp++; if (g !== e) begin n_bad++; $display("FAIL rst_mid_data: got d=%h l=%b expected d=%h l=0", g.d, g.l, e.d); end
        e = crc_beat(32'h76543210);
        g = q_at(1);
        n_cmp++; if (g !== e) begin n_bad++; $display("FAIL rst_mid_crc: got d=%h l=%b expected d=%h l=1", g.d, g.l, e.d); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_crc_delay();
        test_backpressure();
        test_crc_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
